orv64_irf_dbg_port: RTL and testbench

ORV64_IRF_DBG_PORT -- requirements
Module: orv64_irf_dbg_port

---
 rtl/orv64_irf_dbg_port_if.sv | 40 ++++
 rtl/orv64_irf_dbg_port.sv | 151 +++++++++++++++
 tb/tb_orv64_irf_dbg_port.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/orv64_irf_dbg_port_if.sv
// Debug access bus for the orv64 integer register file: debugger request/response
// channels, regfile read/write ports, and pipeline write-port activity.
interface orv64_irf_dbg_port_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [4:0]      req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            core_halted;
  logic            dbg_re;
  logic [4:0]      dbg_ra;
  logic [XLEN-1:0] dbg_rd;
  logic            ma_rd_we;
  logic [4:0]      ma_rd_addr;
  logic            dbg_we;
  logic [4:0]      dbg_wa;
  logic [XLEN-1:0] dbg_wd;

  // Debug-port side: takes requests, returns responses, drives regfile ports.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  core_halted, dbg_rd, ma_rd_we,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dbg_re, dbg_ra, dbg_we, dbg_wa, dbg_wd
  );

  // Debugger / core side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output core_halted, dbg_rd, ma_rd_we, ma_rd_addr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dbg_re, dbg_ra, dbg_we, dbg_wa, dbg_wd
  );
endinterface

// File: rtl/orv64_irf_dbg_port.sv
// Debug read/write access to the integer regfile while the core is halted.
// Reads take the regfile read port for one cycle; writes steal an idle write-port cycle or time out.
module orv64_irf_dbg_port #(
  parameter int XLEN       = 64,
  parameter int WR_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  orv64_irf_dbg_port_if.slave dbg
);

  localparam logic [7:0] WR_TMO = 8'(WR_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t          state_q;
  logic            rdy_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      wait_cnt_q;
  logic            re_q;
  logic [4:0]      ra_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  logic            accept;
  logic            wr_x0;
  logic            wr_slot;
  logic [7:0]      wait_cnt_d;

  assign accept     = dbg.req_valid & rdy_q;
  assign wr_x0      = (addr_q == 5'd0);
  assign wait_cnt_d = wait_cnt_q + 8'd1;

  // The write strobe must see this cycle's pipeline write-port activity, so it
  // cannot be registered; everything else leaving the block is a flop.
  assign wr_slot = (state_q == WR_WAIT) & ~dbg.ma_rd_we & ~wr_x0;

  assign dbg.req_ready = rdy_q;
  assign dbg.rsp_valid = rsp_valid_q;
  assign dbg.rsp_rdata = rsp_rdata_q;
  assign dbg.rsp_err   = rsp_err_q;
  assign dbg.dbg_re    = re_q;
  assign dbg.dbg_ra    = ra_q;
  assign dbg.dbg_we    = wr_slot;
  assign dbg.dbg_wa    = wr_slot ? addr_q  : 5'd0;
  assign dbg.dbg_wd    = wr_slot ? wdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      addr_q      <= 5'd0;
      wdata_q     <= '0;
      wait_cnt_q  <= 8'd0;
      re_q        <= 1'b0;
      ra_q        <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      re_q <= 1'b0;
      ra_q <= 5'd0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            rdy_q   <= 1'b0;
            addr_q  <= dbg.req_addr;
            wdata_q <= dbg.req_wdata;
            if (!dbg.core_halted) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else if (dbg.req_we) begin
              state_q    <= WR_WAIT;
              wait_cnt_q <= 8'd0;
            end else if (dbg.req_addr == 5'd0) begin
              // x0 reads as zero; no need to touch the regfile port.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q <= RD_ISSUE;
              re_q    <= 1'b1;
              ra_q    <= dbg.req_addr;
            end
          end else begin
            // Also raises ready on the first clock after reset release.
            rdy_q <= 1'b1;
          end
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= dbg.dbg_rd;
          rsp_err_q   <= 1'b0;
        end
        WR_WAIT: begin
          if (wr_x0 || !dbg.ma_rd_we) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end else if (wait_cnt_d == WR_TMO) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        RESP: begin
          if (dbg.rsp_ready) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(dbg.dbg_re && dbg.dbg_we));

  a_pipe_write_priority: assert property (@(posedge clk) disable iff (!rst_n)
    !(dbg.dbg_we && dbg.ma_rd_we));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !dbg.rsp_ready) |=> (rsp_valid_q && $stable(rsp_rdata_q) && $stable(rsp_err_q)));

endmodule

// File: tb/tb_orv64_irf_dbg_port.sv
// Directed bench for orv64_irf_dbg_port: transaction-level predictor checked every
// cycle, plus literal expectations for the key scenarios.
module tb_orv64_irf_dbg_port;
  localparam int XLEN = 64;
  localparam int TMO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  orv64_irf_dbg_port_if #(.XLEN(XLEN)) bus ();

  orv64_irf_dbg_port #(.XLEN(XLEN), .WR_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbg   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] rf_init(input int i);
    if (i == 0) return 64'd0;
    if (i == 5) return 64'hDEAD_BEEF_0000_0001;
    return {32'hC0DE_0000 + 32'(i), 32'(i * i)};
  endfunction

  // Behavioural register file answering the debug ports.
  logic [63:0] rf [32];
  logic        rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
      rf_loaded <= 1'b1;
    end else if (bus.dbg_we) begin
      rf[bus.dbg_wa] <= bus.dbg_wd;
    end
    if (bus.dbg_re) bus.dbg_rd <= rf[bus.dbg_ra];
    else            bus.dbg_rd <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Current transaction description, set by the driver before req_valid rises.
  bit          t_we;
  logic [4:0]  t_addr;
  logic [63:0] t_wd;
  bit          t_h;
  int          t_c;

  // Per-transaction observations for the literal checks.
  int          rec_vld_k, rec_vld_n, rec_re_cnt, rec_we_cnt, rec_we_k;
  logic [63:0] rec_rdata;
  logic        rec_err;

  logic [63:0] mdl_rf [32];

  // Compare process: predicts each accepted access from the access rules and
  // checks every output on every cycle.
  initial begin
    int k, rel_k, lat, re_k, we_k;
    bit on;
    logic [63:0] e_rd, wd;
    logic        e_err;
    logic [4:0]  a;
    for (int i = 0; i < 32; i++) mdl_rf[i] = rf_init(i);
    on = 0; k = 0; rel_k = 0; lat = 0; re_k = 0; we_k = 0;
    e_rd = '0; e_err = 1'b0; a = '0; wd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err), 64'd0);
        chk("rst_dbg_re",    64'(bus.dbg_re), 64'd0);
        chk("rst_dbg_ra",    64'(bus.dbg_ra), 64'd0);
        chk("rst_dbg_we",    64'(bus.dbg_we), 64'd0);
        chk("rst_dbg_wa",    64'(bus.dbg_wa), 64'd0);
        chk("rst_dbg_wd",    bus.dbg_wd, 64'd0);
        on = 0;
        rel_k = 0;
      end else if (on) begin
        k++;
        chk("busy_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(k >= lat));
        if (k >= lat) begin
          chk("rsp_rdata", bus.rsp_rdata, e_rd);
          chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
        end
        chk("dbg_re", 64'(bus.dbg_re), 64'(k == re_k));
        if (k == re_k) chk("dbg_ra", 64'(bus.dbg_ra), 64'(a));
        chk("dbg_we", 64'(bus.dbg_we), 64'(k == we_k));
        if (k == we_k) begin
          chk("dbg_wa", 64'(bus.dbg_wa), 64'(a));
          chk("dbg_wd", bus.dbg_wd, wd);
        end
        if (bus.rsp_valid) begin
          if (rec_vld_k == 0) rec_vld_k = k;
          rec_vld_n++;
          rec_rdata = bus.rsp_rdata;
          rec_err   = bus.rsp_err;
        end
        if (bus.dbg_re) rec_re_cnt++;
        if (bus.dbg_we) begin rec_we_cnt++; rec_we_k = k; end
        if (bus.rsp_valid && bus.rsp_ready) begin
          on = 0;
          if (we_k != 0) mdl_rf[a] = wd;
        end
      end else begin
        chk("idle_req_ready", 64'(bus.req_ready), 64'(rel_k >= 1));
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_dbg_re",    64'(bus.dbg_re), 64'd0);
        chk("idle_dbg_we",    64'(bus.dbg_we), 64'd0);
        if (rel_k < 2) rel_k++;
        if (bus.req_valid && bus.req_ready) begin
          a = t_addr; wd = t_wd;
          re_k = 0; we_k = 0; e_rd = '0; e_err = 1'b0;
          if (!t_h) begin
            lat = 1; e_err = 1'b1;
          end else if (!t_we) begin
            if (a == 5'd0) lat = 1;
            else begin lat = 3; re_k = 1; e_rd = mdl_rf[a]; end
          end else if (a == 5'd0) begin
            lat = 2;
          end else if (t_c < TMO) begin
            we_k = t_c + 1; lat = t_c + 2;
          end else begin
            lat = TMO + 1; e_err = 1'b1;
          end
          rec_vld_k = 0; rec_vld_n = 0; rec_re_cnt = 0; rec_we_cnt = 0; rec_we_k = 0;
          rec_rdata = '0; rec_err = 1'b0;
          on = 1;
          k = 0;
        end
      end
    end
  end

  // One access: c = cycles of pipeline write-port contention after accept,
  // d = valid cycles before rsp_ready rises, rst_at = cycle to pulse reset (0 = none).
  task automatic run(input bit we, input logic [4:0] a, input logic [63:0] wd,
                     input bit h, input int c, input int d, input bit drop_h, input int rst_at);
    bit acc, done;
    int vseen;
    t_we = we; t_addr = a; t_wd = wd; t_h = h; t_c = c;
    bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    bus.core_halted = h;
    bus.req_valid = 1'b1;
    acc = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
    if (!acc) return;
    vseen = 0;
    done = 0;
    for (int j = 1; j <= 100 && !done; j++) begin
      bus.ma_rd_we   = (j <= c);
      bus.ma_rd_addr = 5'(j);
      bus.rsp_ready  = (vseen >= d);
      if (drop_h) bus.core_halted = 1'b0;
      if (j == rst_at) rst_n = 1'b0;
      @(negedge clk);
      if (bus.rsp_valid) vseen++;
      done = (bus.rsp_valid && bus.rsp_ready) || !rst_n;
      @(posedge clk); #1;
    end
    chk("txn_done", 64'(done), 64'd1);
    bus.ma_rd_we = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.core_halted = 1'b1;
    if (!rst_n) rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.core_halted = 1'b1; bus.ma_rd_we = 1'b0; bus.ma_rd_addr = '0;
    t_we = 0; t_addr = '0; t_wd = '0; t_h = 1; t_c = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(0, 5'd5, 64'd0, 1, 0, 0, 0, 0);
    chk("x5_rdata_lit", rec_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("x5_latency", 64'(rec_vld_k), 64'd3);
    chk("x5_re_pulses", 64'(rec_re_cnt), 64'd1);

    run(1, 5'd10, 64'h1234, 1, 3, 0, 0, 0);
    chk("x10_we_cycle", 64'(rec_we_k), 64'd4);
    chk("x10_we_pulses", 64'(rec_we_cnt), 64'd1);
    chk("x10_err", 64'(rec_err), 64'd0);
    chk("rf_x10", rf[10], 64'h1234);

    run(0, 5'd10, 64'd0, 1, 0, 0, 0, 0);
    chk("x10_readback", rec_rdata, 64'h1234);

    run(1, 5'd20, 64'hCAFE, 1, 0, 0, 0, 0);
    chk("x20_latency", 64'(rec_vld_k), 64'd2);

    run(1, 5'd7, 64'h7777, 1, 100, 0, 0, 0);
    chk("x7_latency", 64'(rec_vld_k), 64'd17);
    chk("x7_we_pulses", 64'(rec_we_cnt), 64'd0);
    chk("x7_err", 64'(rec_err), 64'd1);
    chk("rf_x7", rf[7], 64'hC0DE_0007_0000_0031);

    run(0, 5'd1, 64'd0, 0, 0, 0, 0, 0);
    chk("nohalt_err", 64'(rec_err), 64'd1);
    chk("nohalt_rdata", rec_rdata, 64'd0);
    chk("nohalt_re_pulses", 64'(rec_re_cnt), 64'd0);

    run(1, 5'd0, 64'hFF, 1, 2, 0, 0, 0);
    chk("x0_wr_we_pulses", 64'(rec_we_cnt), 64'd0);
    chk("x0_wr_err", 64'(rec_err), 64'd0);

    run(0, 5'd0, 64'd0, 1, 0, 0, 0, 0);
    chk("x0_rd_rdata", rec_rdata, 64'd0);
    chk("x0_rd_re_pulses", 64'(rec_re_cnt), 64'd0);

    run(0, 5'd3, 64'd0, 1, 4, 5, 0, 0);
    chk("x3_hold_rdata", rec_rdata, 64'hC0DE_0003_0000_0009);
    chk("x3_vld_cycles", 64'(rec_vld_n), 64'd6);

    run(1, 5'd12, 64'h55AA, 1, 0, 0, 1, 0);
    run(0, 5'd12, 64'd0, 1, 0, 0, 0, 0);
    chk("x12_drop_halt_rd", rec_rdata, 64'h55AA);

    run(1, 5'd9, 64'h9999, 1, 100, 0, 0, 5);
    chk("rst_mid_no_rsp", 64'(rec_vld_k), 64'd0);
    chk("rst_mid_no_we", 64'(rec_we_cnt), 64'd0);
    chk("rf_x9", rf[9], 64'hC0DE_0009_0000_0051);

    run(0, 5'd9, 64'd0, 1, 0, 0, 0, 0);
    chk("x9_after_rst", rec_rdata, 64'hC0DE_0009_0000_0051);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
